// File: rtl/conv1d_seq_ctrl.sv
`timescale 1ns/1ps
// conv1d_seq_ctrl: command sequencer for the 1-D convolution PE datapath.
// On an accepted start it walks every output window and emits, per window,
// one CLEAR beat, filt_len MAC beats and one EMIT beat on a valid/ready
// stream. After the last EMIT it pulses done for one cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_valid / start_ready  job request handshake (ready only in IDLE)
//   cfg_ifmap_len/filt_len/stride  job config, sampled at start accept
//   abort                      synchronous abort of a running job
//   cmd_valid / cmd_ready      command stream handshake
//   cmd_op                     00 CLEAR, 01 MAC, 10 EMIT
//   cmd_filt_addr/ifmap_addr   scratchpad addresses (MAC beats only, else 0)
//   cmd_out_idx                current output-window index
//   done                       one-cycle pulse, job complete
//   cfg_err                    one-cycle pulse, illegal config rejected
module conv1d_seq_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] cfg_ifmap_len,
  input  logic [ADDR_W-1:0] cfg_filt_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic              abort,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_filt_addr,
  output logic [ADDR_W-1:0] cmd_ifmap_addr,
  output logic [IDX_W-1:0]  cmd_out_idx,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned OP_W  = 2;
  // base + stride + filt_len needs two extra bits to never wrap
  localparam int unsigned SUM_W = ADDR_W + 2;

  localparam logic [OP_W-1:0] OP_CLEAR = 2'b00;
  localparam logic [OP_W-1:0] OP_MAC   = 2'b01;
  localparam logic [OP_W-1:0] OP_EMIT  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ifmap_len_q, ifmap_len_d;
  logic [ADDR_W-1:0]   filt_len_q, filt_len_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   j_q, j_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                start_ready_q, start_ready_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [OP_W-1:0]     cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0]   cmd_filt_addr_q, cmd_filt_addr_d;
  logic [ADDR_W-1:0]   cmd_ifmap_addr_q, cmd_ifmap_addr_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic                cfg_bad;
  logic                beat_fire;
  logic                last_mac;
  logic                last_win;

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    ifmap_len_d      = ifmap_len_q;
    filt_len_d       = filt_len_q;
    stride_d         = stride_q;
    base_d           = base_q;
    j_d              = j_q;
    idx_d            = idx_q;
    cmd_valid_d      = cmd_valid_q;
    cmd_op_d         = cmd_op_q;
    cmd_filt_addr_d  = cmd_filt_addr_q;
    cmd_ifmap_addr_d = cmd_ifmap_addr_q;
    done_d           = 1'b0;
    cfg_err_d        = 1'b0;
    start_ready_d    = start_ready_q;

    cfg_bad   = (cfg_filt_len == '0) || (cfg_stride == '0) ||
                (cfg_ifmap_len < cfg_filt_len);
    beat_fire = cmd_valid_q && cmd_ready;
    last_mac  = (j_q == (filt_len_q - ADDR_W'(1)));
    // Current window is the last one when the next window would not fit;
    // this replaces N_OUT = (ifmap-filt)/stride + 1 without a divider.
    last_win  = (SUM_W'(base_q) + SUM_W'(stride_q) + SUM_W'(filt_len_q)) >
                SUM_W'(ifmap_len_q);

    unique case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
          ifmap_len_d = cfg_ifmap_len;
          filt_len_d  = cfg_filt_len;
          stride_d    = cfg_stride;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d          = S_CLEAR;
            base_d           = '0;
            j_d              = '0;
            idx_d            = '0;
            cmd_valid_d      = 1'b1;
            cmd_op_d         = OP_CLEAR;
            cmd_filt_addr_d  = '0;
            cmd_ifmap_addr_d = '0;
          end
        end
      end

      S_CLEAR: begin
        if (beat_fire) begin
          state_d          = S_MAC;
          j_d              = '0;
          cmd_op_d         = OP_MAC;
          cmd_filt_addr_d  = '0;
          cmd_ifmap_addr_d = base_q;
        end
      end

      S_MAC: begin
        if (beat_fire) begin
          if (last_mac) begin
            state_d          = S_EMIT;
            cmd_op_d         = OP_EMIT;
            cmd_filt_addr_d  = '0;
            cmd_ifmap_addr_d = '0;
          end else begin
            j_d              = j_q + ADDR_W'(1);
            cmd_filt_addr_d  = j_q + ADDR_W'(1);
            cmd_ifmap_addr_d = base_q + j_q + ADDR_W'(1);
          end
        end
      end

      S_EMIT: begin
        if (beat_fire) begin
          if (last_win) begin
            state_d     = S_DONE;
            cmd_valid_d = 1'b0;
            cmd_op_d    = OP_CLEAR;
            base_d      = '0;
            j_d         = '0;
            idx_d       = '0;
            done_d      = 1'b1;
          end else begin
            state_d  = S_CLEAR;
            cmd_op_d = OP_CLEAR;
            idx_d    = idx_q + IDX_W'(1);
            base_d   = base_q + stride_q;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including a stalled beat
    if (abort && (state_q != S_IDLE)) begin
      state_d          = S_IDLE;
      base_d           = '0;
      j_d              = '0;
      idx_d            = '0;
      cmd_valid_d      = 1'b0;
      cmd_op_d         = OP_CLEAR;
      cmd_filt_addr_d  = '0;
      cmd_ifmap_addr_d = '0;
      done_d           = 1'b0;
    end

    start_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      ifmap_len_q      <= '0;
      filt_len_q       <= '0;
      stride_q         <= '0;
      base_q           <= '0;
      j_q              <= '0;
      idx_q            <= '0;
      start_ready_q    <= 1'b1;
      cmd_valid_q      <= 1'b0;
      cmd_op_q         <= OP_CLEAR;
      cmd_filt_addr_q  <= '0;
      cmd_ifmap_addr_q <= '0;
      done_q           <= 1'b0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      ifmap_len_q      <= ifmap_len_d;
      filt_len_q       <= filt_len_d;
      stride_q         <= stride_d;
      base_q           <= base_d;
      j_q              <= j_d;
      idx_q            <= idx_d;
      start_ready_q    <= start_ready_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_op_q         <= cmd_op_d;
      cmd_filt_addr_q  <= cmd_filt_addr_d;
      cmd_ifmap_addr_q <= cmd_ifmap_addr_d;
      done_q           <= done_d;
      cfg_err_q        <= cfg_err_d;
    end
  end

  assign start_ready    = start_ready_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd_op         = cmd_op_q;
  assign cmd_filt_addr  = cmd_filt_addr_q;
  assign cmd_ifmap_addr = cmd_ifmap_addr_q;
  assign cmd_out_idx    = idx_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;

  // Stream and handshake invariants
  a_beat_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (cmd_valid_q && !cmd_ready && !abort) |=>
      (cmd_valid_q && $stable({cmd_op_q, cmd_filt_addr_q, cmd_ifmap_addr_q, idx_q})));

  a_done_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && start_ready_q));

  a_op_legal: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_valid_q |-> (cmd_op_q != 2'b11));

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
`timescale 1ns/1ps
module tb_conv1d_seq_ctrl;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 8;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] ia;
    logic [IDX_W-1:0]  idx;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [ADDR_W-1:0] cfg_ifmap_len = '0;
  logic [ADDR_W-1:0] cfg_filt_len = '0;
  logic [ADDR_W-1:0] cfg_stride = '0;
  logic              abort = 1'b0;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_filt_addr;
  logic [ADDR_W-1:0] cmd_ifmap_addr;
  logic [IDX_W-1:0]  cmd_out_idx;
  logic              done;
  logic              cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    done_cnt, both_hi, unstable, bubbles, cfg_err_seen;
  bit    timed_out;

  conv1d_seq_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .cfg_ifmap_len(cfg_ifmap_len), .cfg_filt_len(cfg_filt_len), .cfg_stride(cfg_stride),
    .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_filt_addr(cmd_filt_addr), .cmd_ifmap_addr(cmd_ifmap_addr),
    .cmd_out_idx(cmd_out_idx), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input logic [1:0] op, input logic [ADDR_W-1:0] fa,
                               input logic [ADDR_W-1:0] ia, input logic [IDX_W-1:0] idx);
    beat_t b;
    b.op = op; b.fa = fa; b.ia = ia; b.idx = idx;
    return b;
  endfunction

  // Reference sequence: window idx starts at idx*stride and must fit in ifmap
  task automatic model_push(input int ifl, input int fl, input int st);
    for (int idx = 0; idx * st + fl <= ifl; idx++) begin
      exp_q.push_back(mk(2'b00, '0, '0, IDX_W'(idx)));
      for (int j = 0; j < fl; j++)
        exp_q.push_back(mk(2'b01, ADDR_W'(j), ADDR_W'(idx * st + j), IDX_W'(idx)));
      exp_q.push_back(mk(2'b10, '0, '0, IDX_W'(idx)));
    end
  endtask

  task automatic start_job(input int ifl, input int fl, input int st, input logic ab);
    cfg_ifmap_len = ADDR_W'(ifl);
    cfg_filt_len  = ADDR_W'(fl);
    cfg_stride    = ADDR_W'(st);
    start_valid   = 1'b1;
    abort         = ab;
    tick();
    start_valid   = 1'b0;
    abort         = 1'b0;
  endtask

  // Drives cmd_ready and records accepted beats; mode 1 = random ready plus
  // a 5-cycle stall on the first MAC beat seen.
  task automatic collect(input int mode, input int budget);
    int    stall_left = 0;
    bit    stalled = 0;
    bit    have_prev = 0;
    int    after_done = 0;
    beat_t prev, cur;
    obs_q.delete();
    done_cnt = 0; both_hi = 0; unstable = 0; bubbles = 0; cfg_err_seen = 0;
    timed_out = 1'b1;
    prev = '0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (mode == 0) cmd_ready = 1'b1;
      else if (stall_left > 0) begin cmd_ready = 1'b0; stall_left--; end
      else if (!stalled && cmd_valid && cmd_op == 2'b01) begin
        cmd_ready = 1'b0; stall_left = 4; stalled = 1'b1;
      end
      else cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cur = mk(cmd_op, cmd_filt_addr, cmd_ifmap_addr, cmd_out_idx);
      if (done) done_cnt++;
      if (done && start_ready) both_hi++;
      if (cfg_err) cfg_err_seen++;
      if (!cmd_valid && done_cnt == 0) bubbles++;
      if (cmd_valid) begin
        if (have_prev && cur != prev) unstable++;
        if (cmd_ready) begin obs_q.push_back(cur); have_prev = 1'b0; end
        else begin prev = cur; have_prev = 1'b1; end
      end
      if (done_cnt > 0) after_done++;
      tick();
      if (after_done >= 3) begin timed_out = 1'b0; break; end
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({cmd_valid, cmd_op, cmd_filt_addr, cmd_ifmap_addr, cmd_out_idx, done, cfg_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b op=%b fa=%0d ia=%0d idx=%0d done=%b err=%b, required all 0",
               cmd_valid, cmd_op, cmd_filt_addr, cmd_ifmap_addr, cmd_out_idx, done, cfg_err);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (start_ready !== 1'b1 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: start_ready=%b cmd_valid=%b, required 1/0", start_ready, cmd_valid);
    end
  endtask

  task automatic test_job(input string name, input int ifl, input int fl, input int st,
                          input int mode, input logic ab);
    beat_t e, o;
    int    n_exp;
    model_push(ifl, fl, st);
    n_exp = exp_q.size();
    start_job(ifl, fl, st, ab);
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b00 || cmd_out_idx !== '0 || start_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_first_beat: v=%b op=%b idx=%0d sr=%b, required 1/00/0/0",
               name, cmd_valid, cmd_op, cmd_out_idx, start_ready);
    end
    collect(mode, 300);
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("FAIL %s_timeout: done_cnt=%0d beats=%0d, required done within budget", name, done_cnt, obs_q.size());
    end
    n_cmp++;
    if (obs_q.size() !== n_exp) begin
      n_err++;
      $display("FAIL %s_beat_count: got %0d, required %0d", name, obs_q.size(), n_exp);
    end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s_beat%0d: got op=%b fa=%0d ia=%0d idx=%0d, required op=%b fa=%0d ia=%0d idx=%0d",
                 name, k, o.op, o.fa, o.ia, o.idx, e.op, e.fa, e.ia, e.idx);
      end
    end
    exp_q.delete();
    n_cmp++;
    if (done_cnt !== 1 || both_hi !== 0 || cfg_err_seen !== 0) begin
      n_err++;
      $display("FAIL %s_done: done_cycles=%0d done&ready=%0d cfg_err=%0d, required 1/0/0",
               name, done_cnt, both_hi, cfg_err_seen);
    end
    n_cmp++;
    if ((mode == 0 && bubbles !== 0) || unstable !== 0) begin
      n_err++;
      $display("FAIL %s_stream: bubbles=%0d unstable=%0d, required 0/0", name, bubbles, unstable);
    end
  endtask

  task automatic test_basic();
    test_job("case1", 5, 3, 1, 0, 1'b0);
  endtask

  task automatic test_stride();
    test_job("stride2_i7", 7, 3, 2, 0, 1'b0);
    test_job("stride2_i8", 8, 3, 2, 0, 1'b0);
    test_job("single_win", 3, 3, 1, 0, 1'b0);
    test_job("filt1", 4, 1, 3, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    test_job("stall", 5, 3, 1, 1, 1'b0);
    test_job("stall_s2", 9, 2, 3, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_job("b2b_a", 5, 3, 1, 0, 1'b1);
    test_job("b2b_b", 6, 2, 2, 0, 1'b0);
  endtask

  task automatic test_cfg_err();
    int ifl_t[3] = '{5, 5, 2};
    int fl_t[3]  = '{0, 3, 3};
    int st_t[3]  = '{1, 0, 1};
    int bad;
    for (int k = 0; k < 3; k++) begin
      cmd_ready = 1'b1;
      start_job(ifl_t[k], fl_t[k], st_t[k], 1'b0);
      n_cmp++;
      if (cfg_err !== 1'b1 || cmd_valid !== 1'b0 || start_ready !== 1'b1) begin
        n_err++;
        $display("FAIL cfg_err%0d_pulse: err=%b v=%b sr=%b, required 1/0/1", k, cfg_err, cmd_valid, start_ready);
      end
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (cfg_err || done || cmd_valid || !start_ready) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL cfg_err%0d_after: bad_cycles=%0d, required 0", k, bad);
      end
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_abort();
    bit found = 0;
    int bad = 0;
    start_job(5, 3, 1, 1'b0);
    cmd_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (cmd_valid && cmd_op == 2'b01 && cmd_out_idx == IDX_W'(1) && cmd_filt_addr == ADDR_W'(1)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    cmd_ready = 1'b0;
    n_cmp++;
    if (!found || cmd_ifmap_addr !== ADDR_W'(2)) begin
      n_err++;
      $display("FAIL abort_target: found=%b ia=%0d, required 1/2", found, cmd_ifmap_addr);
    end
    tick();
    n_cmp++;
    if (cmd_valid !== 1'b1 || cmd_op !== 2'b01 || cmd_filt_addr !== ADDR_W'(1) || cmd_ifmap_addr !== ADDR_W'(2)) begin
      n_err++;
      $display("FAIL abort_stall_hold: v=%b op=%b fa=%0d ia=%0d, required 1/01/1/2",
               cmd_valid, cmd_op, cmd_filt_addr, cmd_ifmap_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (cmd_valid !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: v=%b sr=%b done=%b, required 0/1/0", cmd_valid, start_ready, done);
    end
    cmd_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done || cmd_valid) bad++;
    end
    cmd_ready = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: bad_cycles=%0d, required 0", bad);
    end
    test_job("after_abort", 5, 3, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    start_job(5, 3, 1, 1'b0);
    cmd_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (cmd_valid && cmd_op == 2'b10) begin found = 1'b1; break; end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rstmid_emit: found=%b, required 1", found);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_valid, cmd_op, cmd_filt_addr, cmd_ifmap_addr, cmd_out_idx, done, cfg_err} !== '0
        || start_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_async: v=%b op=%b fa=%0d ia=%0d idx=%0d done=%b err=%b sr=%b, required 0s and sr=1",
               cmd_valid, cmd_op, cmd_filt_addr, cmd_ifmap_addr, cmd_out_idx, done, cfg_err, start_ready);
    end
    cmd_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (start_ready !== 1'b1 || cmd_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_release: sr=%b v=%b done=%b, required 1/0/0", start_ready, cmd_valid, done);
    end
    test_job("after_reset", 5, 3, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_backpressure();
    test_back_to_back();
    test_cfg_err();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
